// File: rtl/reset_sequencer.sv
// Synchronous reset sequencer: holds a registered reset for HOLD_CYCLES after every request.
// Optional lock qualification of the hold window is enabled by defining RESET_SEQ_LOCK_EN.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
`ifdef RESET_SEQ_LOCK_EN
  input  logic       locked,
`endif
  output logic       out_rst,
  output logic       out_rst_n,
  output logic       rst_done,
  output logic [7:0] rst_count
);

  typedef enum logic [1:0] {StAssert, StHold, StRun} state_e;

  localparam logic [CNT_WIDTH-1:0] HoldLast = CNT_WIDTH'(HOLD_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_rst_q, out_rst_d;
  logic                 out_rst_n_q;
  logic                 rst_done_q, rst_done_d;
  logic [7:0]           rst_count_q, rst_count_d;
  logic                 lock_ok;

`ifdef RESET_SEQ_LOCK_EN
  assign lock_ok = locked;
`else
  assign lock_ok = 1'b1;
`endif

  // rst itself is handled in the state register; here only the software request and lock matter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_rst_d   = 1'b1;
    rst_done_d  = 1'b0;
    rst_count_d = rst_count_q;
    case (state_q)
      StAssert: begin
        if (!sw_rst_req) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (sw_rst_req) begin
          state_d = StAssert;
        end else if (!lock_ok) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          state_d    = StRun;
          out_rst_d  = 1'b0;
          rst_done_d = 1'b1;
          if (rst_count_q != 8'hff) begin
            rst_count_d = rst_count_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StRun: begin
        if (sw_rst_req || !lock_ok) begin
          state_d = StAssert;
        end else begin
          out_rst_d = 1'b0;
        end
      end
      default: state_d = StAssert;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAssert;
      cnt_q       <= '0;
      out_rst_q   <= 1'b1;
      out_rst_n_q <= 1'b0;
      rst_done_q  <= 1'b0;
      rst_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_rst_q   <= out_rst_d;
      out_rst_n_q <= ~out_rst_d;
      rst_done_q  <= rst_done_d;
      rst_count_q <= rst_count_d;
    end
  end

  assign out_rst   = out_rst_q;
  assign out_rst_n = out_rst_n_q;
  assign rst_done  = rst_done_q;
  assign rst_count = rst_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: two instances (hold 16 and hold 1) share the stimulus,
// a countdown reference model queues expectations, monitors pop and compare every cycle.
module tb_reset_sequencer;

  typedef struct packed {
    logic       rst;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sw = 1'b0;
  logic locked = 1'b1;

  logic       or16, orn16, dn16;
  logic [7:0] ct16;
  logic       or1, orn1, dn1;
  logic [7:0] ct1;

  reset_sequencer #(.HOLD_CYCLES(16), .CNT_WIDTH(8)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw),
`ifdef RESET_SEQ_LOCK_EN
    .locked     (locked),
`endif
    .out_rst    (or16),
    .out_rst_n  (orn16),
    .rst_done   (dn16),
    .rst_count  (ct16)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .CNT_WIDTH(4)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw),
`ifdef RESET_SEQ_LOCK_EN
    .locked     (locked),
`endif
    .out_rst    (or1),
    .out_rst_n  (orn1),
    .rst_done   (dn1),
    .rst_count  (ct1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: edges remaining until release (hold+1 means still asserting).
  bit released[2];
  int wait_left[2];
  int count[2];

  task automatic model(input int id, input int h, input bit r, input bit s, input bit l);
    bit d;
    exp_t e;
    d = 1'b0;
    if (r) begin
      released[id]  = 1'b0;
      wait_left[id] = h + 1;
      count[id]     = 0;
    end else if (s || (released[id] && !l)) begin
      released[id]  = 1'b0;
      wait_left[id] = h + 1;
    end else if (!released[id]) begin
      if (!l && wait_left[id] <= h) begin
        wait_left[id] = h;
      end else begin
        wait_left[id] = wait_left[id] - 1;
        if (wait_left[id] == 0) begin
          released[id] = 1'b1;
          d            = 1'b1;
          if (count[id] < 255) count[id] = count[id] + 1;
        end
      end
    end
    e.rst  = !released[id];
    e.done = d;
    e.cnt  = 8'(count[id]);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic step(input bit r, input bit s, input bit l);
    rst    = r;
    sw     = s;
    locked = l;
    model(0, 16, r, s, l);
    model(1, 1, r, s, l);
    @(negedge clk);
  endtask

  task automatic cmp(input string name, input int id, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL dut%0d %s at %0t: got %0d expected %0d", id, name, $time, got, exp_v);
    end
  endtask

  task automatic check(input int id, input logic o, input logic on, input logic d,
                       input logic [7:0] c);
    exp_t e;
    if (id == 0) begin
      if (q0.size() == 0) return;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return;
      e = q1.pop_front();
    end
    cmp("out_rst", id, int'(o), int'(e.rst));
    cmp("out_rst_n", id, int'(on), int'(!e.rst));
    cmp("rst_done", id, int'(d), int'(e.done));
    cmp("rst_count", id, int'(c), int'(e.cnt));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check(0, or16, orn16, dn16, ct16);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check(1, or1, orn1, dn1, ct1);
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      released[i]  = 1'b0;
      wait_left[i] = (i == 0) ? 17 : 2;
      count[i]     = 0;
    end
    // Power-up
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    // One-cycle software pulse in RUN
    step(1'b0, 1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    // Restart mid-hold at cnt=10
    step(1'b0, 1'b1, 1'b1);
    repeat (11) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    // RST mid-run and mid-hold
    step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (25) step(1'b0, 1'b0, 1'b1);
`ifdef RESET_SEQ_LOCK_EN
    // Lock drop at cnt=8, then in RUN
    step(1'b0, 1'b1, 1'b1);
    repeat (9) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b1);
`endif
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r, s, l;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 29) == 0);
`ifdef RESET_SEQ_LOCK_EN
      l = ($urandom_range(0, 24) != 0);
`else
      l = 1'b1;
`endif
      step(r, s, l);
    end
    // Saturation of the hold-1 instance
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b1);
    end
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    cmp("q0_drained", 0, q0.size(), 0);
    cmp("q1_drained", 1, q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
